rr_requester: RTL and testbench
===============================

# rr_requester

Requester-side agent for the round-robin arbiter. It buffers packets from a local producer in a FIFO and raises `Req` once a complete packet is stored. On `Grant` it takes ownership of the shared bus and streams the packet beat by beat, then releases. One instance sits on each arbiter request/grant lane.

## Interface
- `DATA_WIDTH`, 8, payload width of one beat
- `DEPTH`, 8, FIFO depth in beats; power of two, ≥2
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `job_valid`  in  1  producer beat valid
- `job_ready`  out  1  FIFO can accept a beat (= !full)
- `job_data`  in  DATA_WIDTH  producer beat payload
- `job_last`  in  1  beat is last of its packet
- `Req`  out  1  registered request to arbiter lane
- `Grant`  in  1  grant from arbiter lane; may be a single-cycle pulse
- `bus_valid`  out  1  beat on shared bus valid
- `bus_ready`  in  1  bus sink accepts beat
- `bus_data`  out  DATA_WIDTH  beat payload; 0 when `bus_valid`=0
- `bus_last`  out  1  last beat of packet; 0 when `bus_valid`=0
- `ovf_err`  out  1  sticky: FIFO full while holding no complete packet

## Operation
- FIFO: DEPTH entries of {data,last}, with write and read pointers of log2(DEPTH)+1 bits.
  - Push on `job_valid & job_ready`; pop on `bus_valid & bus_ready`.
  - Simultaneous push and pop is legal in any state, including full.
- `pkt_cnt`: number of stored `last` flags, range 0..DEPTH.
  - +1 on pushing a last beat; −1 on popping a last beat; unchanged when both happen in the same cycle.
- FSM states IDLE, REQ, SEND, GAP:
  - IDLE: `pkt_cnt`>0 → REQ.
  - REQ: `Req`=1; `Grant`=1 sampled → SEND; otherwise stay.
  - SEND: `bus_valid`=1 while FIFO is non-empty; on a pop with last=1 → GAP. Ownership holds until the last beat regardless of `Grant`.
  - GAP: one cycle with `Req`=0 → IDLE. This gives other lanes a chance at the arbiter.
- `Grant` outside REQ is ignored.
- A packet whose tail beats are still arriving during SEND is legal. `bus_valid` drops while the FIFO is empty.
- `ovf_err` sets when full=1 and `pkt_cnt`=0, which means the packet is longer than DEPTH. It stays set until reset; the block is then stalled.

## Timing
- Reset values:
  - `Req`=0, `bus_valid`=0, `bus_data`=0, `bus_last`=0, `ovf_err`=0.
  - `job_ready`=1; FIFO empty, `pkt_cnt`=0, state IDLE.
- Reset asserted mid-packet discards all FIFO contents immediately and drops `Req`/`bus_valid` asynchronously.
- Request timing:
  - Last beat pushed at edge E0 → `pkt_cnt` updates at E0.
  - Move to REQ at E1 → `Req` high from E1.
- Grant timing:
  - `Grant` sampled high at edge G → state SEND after G.
  - `Req` falls at G; `bus_valid` rises at G. The first beat is presented the cycle after the grant pulse.
- Bus output:
  - `bus_data`/`bus_last` come combinationally from the FIFO head, gated by `bus_valid`.
  - A beat is held stable until `bus_ready`; one beat per cycle at full throughput.
- Release timing:
  - Last beat popped at edge L → GAP after L, IDLE after L+1.
  - Earliest next `Req` is at L+2, even if more packets are queued.
- `job_ready` deasserts the cycle after the push that fills the FIFO. It reasserts the cycle after any pop.

## Test plan
- Reset, then push 3 beats (0x11, 0x22, 0x33 with last) → `Req`=1 one cycle after the 0x33 push; `bus_valid`=0.
- Pulse `Grant` for 1 cycle with `bus_ready`=1 → `Req` falls; next 3 cycles bus shows 0x11, 0x22, 0x33 with `bus_last` on 0x33; `Req` stays 0 for the GAP cycle.
- Queue two 2-beat packets, grant twice, toggle `bus_ready` 1/0 → beats held stable while stalled, order preserved; `Req` re-rises exactly 2 cycles after the first packet's last pop.
- Push 8 non-last beats with DEPTH=8 → `job_ready`=0, `ovf_err`=1 and sticky; `Req` never rises.
- `Grant` pulses while in IDLE and GAP → ignored; no `bus_valid`; FIFO unchanged.
- Assert `rst_n`=0 mid-SEND → all outputs at reset values immediately; after release the FIFO is empty and `job_ready`=1.

Source files
------------

// File: rtl/rr_requester_if.sv
// Lane bundle between a requester agent, its local producer, the arbiter lane and the shared bus.
// The master modport is the requester side; the slave modport is everything around it.
interface rr_requester_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  job_valid;
    logic                  job_ready;
    logic [DATA_WIDTH-1:0] job_data;
    logic                  job_last;
    logic                  Req;
    logic                  Grant;
    logic                  bus_valid;
    logic                  bus_ready;
    logic [DATA_WIDTH-1:0] bus_data;
    logic                  bus_last;
    logic                  ovf_err;

    modport master (
        input  job_valid, job_data, job_last, Grant, bus_ready,
        output job_ready, Req, bus_valid, bus_data, bus_last, ovf_err
    );

    modport slave (
        output job_valid, job_data, job_last, Grant, bus_ready,
        input  job_ready, Req, bus_valid, bus_data, bus_last, ovf_err
    );
endinterface

// File: rtl/rr_requester.sv
// Requester agent: buffers producer beats, requests the arbiter once a whole packet is stored,
// then streams exactly one packet per grant and idles one cycle so other lanes can win.
module rr_requester #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_requester_if.master       lane
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [PW-1:0]         pkt_cnt_r;
    logic                  req_r;
    logic                  bus_valid_r;
    logic                  job_ready_r;
    logic                  ovf_err_r;
    logic [DATA_WIDTH-1:0] mem_data_r [DEPTH];
    logic                  mem_last_r [DEPTH];

    logic                  push_s;
    logic                  pop_s;
    logic                  head_last_s;
    logic [DATA_WIDTH-1:0] head_data_s;
    logic [PW-1:0]         wr_ptr_nxt_s;
    logic [PW-1:0]         rd_ptr_nxt_s;
    logic [PW-1:0]         count_nxt_s;
    logic [PW-1:0]         pkt_cnt_nxt_s;
    logic                  full_nxt_s;

    // job_ready_r mirrors !full, so a push can never land on a full FIFO
    assign push_s       = lane.job_valid & job_ready_r;
    assign pop_s        = bus_valid_r & lane.bus_ready;
    assign head_data_s  = mem_data_r[rd_ptr_r[AW-1:0]];
    assign head_last_s  = mem_last_r[rd_ptr_r[AW-1:0]];
    assign wr_ptr_nxt_s = wr_ptr_r + (push_s ? PW'(1) : PW'(0));
    assign rd_ptr_nxt_s = rd_ptr_r + (pop_s ? PW'(1) : PW'(0));
    assign count_nxt_s  = wr_ptr_nxt_s - rd_ptr_nxt_s;
    assign full_nxt_s   = (count_nxt_s == PW'(DEPTH));

    // Packet counter update: simultaneous last-push and last-pop cancel out
    always_comb begin
        pkt_cnt_nxt_s = pkt_cnt_r;
        case ({push_s & lane.job_last, pop_s & head_last_s})
            2'b10:   pkt_cnt_nxt_s = pkt_cnt_r + PW'(1);
            2'b01:   pkt_cnt_nxt_s = pkt_cnt_r - PW'(1);
            default: pkt_cnt_nxt_s = pkt_cnt_r;
        endcase
    end

    // Lane state transitions; Grant only matters while requesting
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pkt_cnt_r != PW'(0)) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (lane.Grant) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            SEND: begin
                if (pop_s && head_last_s) begin
                    state_nxt_s = GAP;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            GAP:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM, pointers, counters and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            pkt_cnt_r   <= '0;
            req_r       <= 1'b0;
            bus_valid_r <= 1'b0;
            job_ready_r <= 1'b1;
            ovf_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            pkt_cnt_r   <= pkt_cnt_nxt_s;
            req_r       <= (state_nxt_s == REQ);
            // Valid only when the head will hold a real beat, so a tail still arriving stalls the bus
            bus_valid_r <= (state_nxt_s == SEND) && (count_nxt_s != PW'(0));
            job_ready_r <= !full_nxt_s;
            // Full with no complete packet can never drain: the packet exceeds the buffer
            ovf_err_r   <= ovf_err_r | (full_nxt_s && (pkt_cnt_nxt_s == PW'(0)));
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset is needed
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_data_r[wr_ptr_r[AW-1:0]] <= lane.job_data;
            mem_last_r[wr_ptr_r[AW-1:0]] <= lane.job_last;
        end
    end

    assign lane.job_ready = job_ready_r;
    assign lane.Req       = req_r;
    assign lane.bus_valid = bus_valid_r;
    assign lane.bus_data  = bus_valid_r ? head_data_s : {DATA_WIDTH{1'b0}};
    assign lane.bus_last  = bus_valid_r & head_last_s;
    assign lane.ovf_err   = ovf_err_r;
endmodule

// File: tb/tb_rr_requester.sv
// Directed bench for rr_requester: request/grant timing, bus streaming with stalls,
// grant filtering, overflow detection and asynchronous reset mid-packet.
module tb_rr_requester;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rr_requester_if #(.DATA_WIDTH(8)) vif ();

    rr_requester #(.DATA_WIDTH(8), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lane  (vif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_beat(input logic [7:0] d, input logic l);
        vif.job_valid = 1'b1;
        vif.job_data  = d;
        vif.job_last  = l;
        @(negedge clk);
        vif.job_valid = 1'b0;
        vif.job_last  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (vif.Req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", vif.Req); end
        checks++; if (vif.bus_valid !== 1'b0) begin errors++; $display("FAIL reset_bus_valid: got %b want 0", vif.bus_valid); end
        checks++; if (vif.bus_data !== 8'h00) begin errors++; $display("FAIL reset_bus_data: got %h want 00", vif.bus_data); end
        checks++; if (vif.bus_last !== 1'b0) begin errors++; $display("FAIL reset_bus_last: got %b want 0", vif.bus_last); end
        checks++; if (vif.ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", vif.ovf_err); end
        checks++; if (vif.job_ready !== 1'b1) begin errors++; $display("FAIL reset_job_ready: got %b want 1", vif.job_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (vif.Req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", vif.Req); end
    endtask

    task automatic test_request();
        push_beat(8'h11, 1'b0);
        push_beat(8'h22, 1'b0);
        push_beat(8'h33, 1'b1);
        checks++; if (vif.Req !== 1'b0) begin errors++; $display("FAIL req_at_E0: got %b want 0", vif.Req); end
        @(negedge clk);
        checks++; if (vif.Req !== 1'b1) begin errors++; $display("FAIL req_at_E1: got %b want 1", vif.Req); end
        checks++; if (vif.bus_valid !== 1'b0) begin errors++; $display("FAIL req_bus_valid: got %b want 0", vif.bus_valid); end
    endtask

    task automatic test_grant();
        vif.Grant = 1'b1; vif.bus_ready = 1'b1;
        @(negedge clk);
        vif.Grant = 1'b0;
        checks++; if (vif.Req !== 1'b0) begin errors++; $display("FAIL grant_req_fall: got %b want 0", vif.Req); end
        checks++; if ({vif.bus_valid, vif.bus_data, vif.bus_last} !== {1'b1, 8'h11, 1'b0}) begin errors++; $display("FAIL grant_beat0: got v=%b d=%h l=%b want v=1 d=11 l=0", vif.bus_valid, vif.bus_data, vif.bus_last); end
        @(negedge clk);
        checks++; if ({vif.bus_valid, vif.bus_data, vif.bus_last} !== {1'b1, 8'h22, 1'b0}) begin errors++; $display("FAIL grant_beat1: got v=%b d=%h l=%b want v=1 d=22 l=0", vif.bus_valid, vif.bus_data, vif.bus_last); end
        @(negedge clk);
        checks++; if ({vif.bus_valid, vif.bus_data, vif.bus_last} !== {1'b1, 8'h33, 1'b1}) begin errors++; $display("FAIL grant_beat2: got v=%b d=%h l=%b want v=1 d=33 l=1", vif.bus_valid, vif.bus_data, vif.bus_last); end
        @(negedge clk);
        checks++; if ({vif.Req, vif.bus_valid, vif.bus_data} !== {1'b0, 1'b0, 8'h00}) begin errors++; $display("FAIL grant_gap: got r=%b v=%b d=%h want r=0 v=0 d=00", vif.Req, vif.bus_valid, vif.bus_data); end
        vif.bus_ready = 1'b0;
        @(negedge clk);
        checks++; if (vif.Req !== 1'b0) begin errors++; $display("FAIL grant_idle_req: got %b want 0", vif.Req); end
    endtask

    task automatic test_back_to_back();
        push_beat(8'hA1, 1'b0);
        push_beat(8'hA2, 1'b1);
        push_beat(8'hB1, 1'b0);
        push_beat(8'hB2, 1'b1);
        checks++; if (vif.Req !== 1'b1) begin errors++; $display("FAIL b2b_req: got %b want 1", vif.Req); end
        vif.Grant = 1'b1; vif.bus_ready = 1'b0;
        @(negedge clk);
        vif.Grant = 1'b0;
        checks++; if ({vif.bus_valid, vif.bus_data} !== {1'b1, 8'hA1}) begin errors++; $display("FAIL b2b_a1: got v=%b d=%h want v=1 d=a1", vif.bus_valid, vif.bus_data); end
        @(negedge clk);
        checks++; if ({vif.bus_valid, vif.bus_data} !== {1'b1, 8'hA1}) begin errors++; $display("FAIL b2b_a1_held: got v=%b d=%h want v=1 d=a1", vif.bus_valid, vif.bus_data); end
        vif.bus_ready = 1'b1;
        @(negedge clk);
        vif.bus_ready = 1'b0;
        checks++; if ({vif.bus_valid, vif.bus_data, vif.bus_last} !== {1'b1, 8'hA2, 1'b1}) begin errors++; $display("FAIL b2b_a2: got v=%b d=%h l=%b want v=1 d=a2 l=1", vif.bus_valid, vif.bus_data, vif.bus_last); end
        @(negedge clk);
        checks++; if ({vif.bus_valid, vif.bus_data, vif.bus_last} !== {1'b1, 8'hA2, 1'b1}) begin errors++; $display("FAIL b2b_a2_held: got v=%b d=%h l=%b want v=1 d=a2 l=1", vif.bus_valid, vif.bus_data, vif.bus_last); end
        vif.bus_ready = 1'b1;
        @(negedge clk);
        vif.bus_ready = 1'b0;
        checks++; if ({vif.Req, vif.bus_valid} !== 2'b00) begin errors++; $display("FAIL b2b_gap: got r=%b v=%b want r=0 v=0", vif.Req, vif.bus_valid); end
        @(negedge clk);
        checks++; if (vif.Req !== 1'b0) begin errors++; $display("FAIL b2b_req_L1: got %b want 0", vif.Req); end
        @(negedge clk);
        checks++; if (vif.Req !== 1'b1) begin errors++; $display("FAIL b2b_req_L2: got %b want 1", vif.Req); end
        vif.Grant = 1'b1; vif.bus_ready = 1'b1;
        @(negedge clk);
        vif.Grant = 1'b0;
        checks++; if ({vif.bus_valid, vif.bus_data, vif.bus_last} !== {1'b1, 8'hB1, 1'b0}) begin errors++; $display("FAIL b2b_b1: got v=%b d=%h l=%b want v=1 d=b1 l=0", vif.bus_valid, vif.bus_data, vif.bus_last); end
        @(negedge clk);
        checks++; if ({vif.bus_valid, vif.bus_data, vif.bus_last} !== {1'b1, 8'hB2, 1'b1}) begin errors++; $display("FAIL b2b_b2: got v=%b d=%h l=%b want v=1 d=b2 l=1", vif.bus_valid, vif.bus_data, vif.bus_last); end
        @(negedge clk);
        vif.bus_ready = 1'b0;
        checks++; if (vif.bus_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap2: got %b want 0", vif.bus_valid); end
        repeat (2) @(negedge clk);
        checks++; if (vif.Req !== 1'b0) begin errors++; $display("FAIL b2b_drained_req: got %b want 0", vif.Req); end
    endtask

    task automatic test_grant_ignored();
        vif.Grant = 1'b1;
        @(negedge clk);
        vif.Grant = 1'b0;
        checks++; if ({vif.Req, vif.bus_valid} !== 2'b00) begin errors++; $display("FAIL ign_idle: got r=%b v=%b want r=0 v=0", vif.Req, vif.bus_valid); end
        push_beat(8'hC3, 1'b1);
        push_beat(8'hD4, 1'b1);
        checks++; if (vif.Req !== 1'b1) begin errors++; $display("FAIL ign_req: got %b want 1", vif.Req); end
        vif.Grant = 1'b1; vif.bus_ready = 1'b1;
        @(negedge clk);
        vif.Grant = 1'b0;
        checks++; if ({vif.bus_valid, vif.bus_data, vif.bus_last} !== {1'b1, 8'hC3, 1'b1}) begin errors++; $display("FAIL ign_c3: got v=%b d=%h l=%b want v=1 d=c3 l=1", vif.bus_valid, vif.bus_data, vif.bus_last); end
        @(negedge clk);
        vif.Grant = 1'b1;
        checks++; if (vif.bus_valid !== 1'b0) begin errors++; $display("FAIL ign_gap_valid: got %b want 0", vif.bus_valid); end
        @(negedge clk);
        vif.Grant = 1'b0;
        checks++; if ({vif.Req, vif.bus_valid} !== 2'b00) begin errors++; $display("FAIL ign_after_gap: got r=%b v=%b want r=0 v=0", vif.Req, vif.bus_valid); end
        @(negedge clk);
        checks++; if ({vif.Req, vif.bus_valid} !== 2'b10) begin errors++; $display("FAIL ign_rereq: got r=%b v=%b want r=1 v=0", vif.Req, vif.bus_valid); end
        vif.Grant = 1'b1;
        @(negedge clk);
        vif.Grant = 1'b0;
        checks++; if ({vif.bus_valid, vif.bus_data, vif.bus_last} !== {1'b1, 8'hD4, 1'b1}) begin errors++; $display("FAIL ign_d4: got v=%b d=%h l=%b want v=1 d=d4 l=1", vif.bus_valid, vif.bus_data, vif.bus_last); end
        @(negedge clk);
        vif.bus_ready = 1'b0;
        checks++; if (vif.bus_valid !== 1'b0) begin errors++; $display("FAIL ign_final_gap: got %b want 0", vif.bus_valid); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_send();
        push_beat(8'h01, 1'b0);
        push_beat(8'h02, 1'b0);
        push_beat(8'h03, 1'b1);
        @(negedge clk);
        vif.Grant = 1'b1; vif.bus_ready = 1'b1;
        @(negedge clk);
        vif.Grant = 1'b0;
        checks++; if ({vif.bus_valid, vif.bus_data} !== {1'b1, 8'h01}) begin errors++; $display("FAIL rst_beat0: got v=%b d=%h want v=1 d=01", vif.bus_valid, vif.bus_data); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({vif.Req, vif.bus_valid, vif.bus_data, vif.bus_last} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin errors++; $display("FAIL rst_async: got r=%b v=%b d=%h l=%b want all 0", vif.Req, vif.bus_valid, vif.bus_data, vif.bus_last); end
        checks++; if (vif.job_ready !== 1'b1) begin errors++; $display("FAIL rst_job_ready: got %b want 1", vif.job_ready); end
        vif.bus_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({vif.Req, vif.bus_valid, vif.job_ready} !== 3'b001) begin errors++; $display("FAIL rst_empty: got r=%b v=%b jr=%b want r=0 v=0 jr=1", vif.Req, vif.bus_valid, vif.job_ready); end
        push_beat(8'h5A, 1'b1);
        @(negedge clk);
        vif.Grant = 1'b1; vif.bus_ready = 1'b1;
        @(negedge clk);
        vif.Grant = 1'b0;
        checks++; if ({vif.bus_valid, vif.bus_data, vif.bus_last} !== {1'b1, 8'h5A, 1'b1}) begin errors++; $display("FAIL rst_fresh_head: got v=%b d=%h l=%b want v=1 d=5a l=1", vif.bus_valid, vif.bus_data, vif.bus_last); end
        repeat (2) @(negedge clk);
        vif.bus_ready = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                checks++; if ({vif.job_ready, vif.ovf_err} !== 2'b10) begin errors++; $display("FAIL ovf_before_full: got jr=%b ovf=%b want jr=1 ovf=0", vif.job_ready, vif.ovf_err); end
            end
            push_beat(8'(i), 1'b0);
        end
        checks++; if ({vif.job_ready, vif.ovf_err} !== 2'b01) begin errors++; $display("FAIL ovf_full: got jr=%b ovf=%b want jr=0 ovf=1", vif.job_ready, vif.ovf_err); end
        vif.job_valid = 1'b1; vif.job_data = 8'hEE; vif.job_last = 1'b1;
        repeat (3) @(negedge clk);
        vif.job_valid = 1'b0; vif.job_last = 1'b0;
        checks++; if ({vif.ovf_err, vif.Req, vif.job_ready} !== 3'b100) begin errors++; $display("FAIL ovf_sticky: got ovf=%b r=%b jr=%b want ovf=1 r=0 jr=0", vif.ovf_err, vif.Req, vif.job_ready); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({vif.ovf_err, vif.job_ready} !== 2'b01) begin errors++; $display("FAIL ovf_cleared: got ovf=%b jr=%b want ovf=0 jr=1", vif.ovf_err, vif.job_ready); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        vif.job_valid = 1'b0;
        vif.job_data  = 8'h00;
        vif.job_last  = 1'b0;
        vif.Grant     = 1'b0;
        vif.bus_ready = 1'b0;
        test_reset();
        test_request();
        test_grant();
        test_back_to_back();
        test_grant_ignored();
        test_reset_mid_send();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
